// File: rtl/mont_cond_sub.sv
// mont_cond_sub: final conditional subtraction for the Montgomery datapath.
//
// Given X (the multi-precision adder result, including its carry bit) and the
// modulus M, this computes X - M one CHUNK-bit slice per cycle. The borrow
// chain is held in a register between slices. The final carry decides the
// result: X - M when X >= M, otherwise X unchanged.
//
// Ports:
//   clk_i      system clock; all state changes on the rising edge
//   reset_i    synchronous, active-high reset; aborts any operation in flight
//   start_i    one-cycle request; samples in_x_i/in_m_i, honoured only when idle
//   in_x_i     W-bit value to reduce
//   in_m_i     (W-1)-bit modulus, zero-extended internally
//   result_o   reduced value; valid from the done cycle, held until next result
//   reduced_o  1 when the subtraction was applied (X >= M)
//   busy_o     high from the accepted start until done deasserts
//   done_o     one-cycle pulse marking result_o/reduced_o valid

module mont_cond_sub #(
    parameter int unsigned CHUNK  = 257,
    parameter int unsigned NCHUNK = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [CHUNK*NCHUNK-1:0]   in_x_i,
    input  logic [CHUNK*NCHUNK-2:0]   in_m_i,
    output logic [CHUNK*NCHUNK-1:0]   result_o,
    output logic                      reduced_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned W = CHUNK * NCHUNK;

    typedef enum logic [1:0] {
        StIdle,
        StSub,
        StSel,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       x_q, x_d;
    logic [W-1:0]       m_q, m_d;
    logic [W-1:0]       d_q, d_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       result_q, result_d;
    logic               reduced_q, reduced_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // One slice of X + ~M + carry. The initial carry of 1 turns this into
    // X - M; the final carry out is 1 exactly when no borrow occurred (X >= M).
    logic [CHUNK:0]     sum;

    assign sum = {1'b0, x_q[CHUNK-1:0]}
               + {1'b0, ~m_q[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, carry_q};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        m_d       = m_q;
        d_d       = d_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        result_d  = result_q;
        reduced_d = reduced_q;
        busy_d    = busy_q;
        done_d    = done_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    x_d     = in_x_i;
                    m_d     = {1'b0, in_m_i};
                    d_d     = '0;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StSub;
                end
            end

            StSub: begin
                carry_d = sum[CHUNK];
                // Difference slices enter at the top and shift down, so after
                // NCHUNK slices chunk 0 sits in the least significant position.
                d_d     = {sum[CHUNK-1:0], d_q[W-1:CHUNK]};
                // Rotating rather than shifting leaves X intact after NCHUNK
                // steps, so the original value is still there for the select.
                x_d     = {x_q[CHUNK-1:0], x_q[W-1:CHUNK]};
                m_d     = {m_q[CHUNK-1:0], m_q[W-1:CHUNK]};
                idx_d   = idx_q + CNT_W'(1);
                if (idx_q == CNT_W'(NCHUNK - 1)) begin
                    state_d = StSel;
                end
            end

            StSel: begin
                result_d  = carry_q ? d_q : x_q;
                reduced_d = carry_q;
                done_d    = 1'b1;
                state_d   = StDone;
            end

            StDone: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            x_q       <= '0;
            m_q       <= '0;
            d_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            result_q  <= '0;
            reduced_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            m_q       <= m_d;
            d_q       <= d_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            reduced_q <= reduced_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign result_o  = result_q;
    assign reduced_o = reduced_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_mont_cond_sub.sv
// Directed and random checks for mont_cond_sub.
module tb_mont_cond_sub;

    localparam int unsigned W = 1028;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   in_x;
    logic [W-2:0]   in_m;
    logic [W-1:0]   result;
    logic           reduced;
    logic           busy;
    logic           done;

    int n_checks;
    int n_pass;

    mont_cond_sub dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .in_x_i    (in_x),
        .in_m_i    (in_m),
        .result_o  (result),
        .reduced_o (reduced),
        .busy_o    (busy),
        .done_o    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got lo=%h required lo=%h high_bits_differ=%0d",
                   tag, obs[255:0], exp[255:0], obs[W-1:256] !== exp[W-1:256]);
        end
    endtask

    // Runs one operation starting now; full adds latency/busy/hold checks.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] m,
                          input logic [W-1:0] exp_res, input logic exp_red,
                          input string tag, input bit full);
        int  lat;
        bit  seen;
        in_x  = x;
        in_m  = m[W-2:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        in_x  = '1;          // inputs may change freely after the accept edge
        in_m  = '0;
        lat   = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            lat++;
            seen = done;
        end
        chk({tag, "_done_seen"}, W'(seen), W'(1));
        if (seen) begin
            chk({tag, "_result"}, result, exp_res);
            chk({tag, "_reduced"}, W'(reduced), W'(exp_red));
            if (full) begin
                chk({tag, "_latency"}, W'(lat), W'(5));
                chk({tag, "_busy_at_done"}, W'(busy), W'(1));
                tick();
                chk({tag, "_done_pulse"}, W'(done), W'(0));
                chk({tag, "_busy_after"}, W'(busy), W'(0));
                chk({tag, "_result_hold"}, result, exp_res);
            end else begin
                tick();
            end
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < 33; k++) begin
            v = (v << 32) | W'($urandom());
        end
        return v;
    endfunction

    logic [W-1:0] m_big;
    logic [W-1:0] one;
    logic [W-1:0] bb_res [3];
    logic         bb_red [3];
    logic [W-1:0] rm;
    logic [W-1:0] rr;
    logic [W-1:0] rx;
    logic [W-1:0] rexp;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_x     = '0;
        in_m     = '0;
        one      = W'(1);

        // Reset state
        tick();
        tick();
        chk("rst_result", result, '0);
        chk("rst_reduced", W'(reduced), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        reset = 1'b0;
        tick();

        // M = 2^1026 + 3
        m_big = (one << 1026) + W'(3);
        run_op(m_big + W'(5), m_big, W'(5), 1'b1, "xgtm", 1'b1);
        run_op(m_big - W'(1), m_big, m_big - W'(1), 1'b0, "xltm", 1'b1);
        run_op(m_big, m_big, '0, 1'b1, "xeqm", 1'b1);

        // Borrow across slice boundaries
        run_op(one << 257, W'(1), (one << 257) - W'(1), 1'b1, "borrow257", 1'b1);
        run_op({W{1'b1}}, (one << 1027) - W'(1), one << 1027, 1'b1, "topbits", 1'b1);

        // start held high 20 cycles, in_x changing every cycle, M = 100.
        // Accepts at edges 0, 7, 14 with in_x = 90, 125, 160.
        bb_res[0] = W'(90);  bb_red[0] = 1'b0;
        bb_res[1] = W'(25);  bb_red[1] = 1'b1;
        bb_res[2] = W'(60);  bb_red[2] = 1'b1;
        in_m = (W-1)'(100);
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            in_x  = W'(90 + 5 * i);
            tick();
            if (i % 7 == 5) begin
                chk("b2b_done", W'(done), W'(1));
                chk("b2b_result", result, bb_res[i / 7]);
                chk("b2b_reduced", W'(reduced), W'(bb_red[i / 7]));
            end else begin
                chk("b2b_no_done", W'(done), W'(0));
            end
        end
        start = 1'b0;
        tick();

        // Reset during the second SUB cycle aborts the operation
        in_x  = W'(1000);
        in_m  = (W-1)'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_result", result, '0);
        chk("midrst_reduced", W'(reduced), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("midrst_no_done", W'(done), W'(0));
        end
        run_op(W'(10), W'(3), W'(7), 1'b1, "after_rst", 1'b1);

        // Random regression: X < 2M, M < 2^1027
        for (int n = 0; n < 1000; n++) begin
            rm = rand_wide();
            rm[W-1] = 1'b0;
            rm[0]   = 1'b1;
            rr = rand_wide() & (rm >> 1);
            rx = ($urandom_range(0, 1) == 1) ? (rm + rr) : rr;
            if (n == 0) rx = rm;
            rexp = (rx >= rm) ? (rx - rm) : rx;
            run_op(rx, rm, rexp, rx >= rm, "rand", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
